// File: rtl/coffee_dispense_ctrl_if.sv
// rtl/coffee_dispense_ctrl_if.sv - request, sensor, actuator and status bundle for coffee_dispense_ctrl
//
// Purpose: groups every non-clock/reset signal of coffee_dispense_ctrl.
// Signals:
//   dispense     request pulse from the coin-summing FSM (master -> slave)
//   cup_present  cup sensor, 1 = cup in place          (master -> slave)
//   cup_drop, heater_on, valve_open  actuator enables  (slave -> master)
//   served       one-cycle pulse on the final DONE cycle
//   busy         high whenever the serve FSM is not IDLE
//   credits      buffered requests not yet started
//   overflow     one-cycle pulse when a request is dropped
//   LED_Green    ready LED, LED_Yellow busy LED
// Modports: master (request source / status sink), slave (the controller).

interface coffee_dispense_ctrl_if;
    logic       dispense;
    logic       cup_present;
    logic       cup_drop;
    logic       heater_on;
    logic       valve_open;
    logic       served;
    logic       busy;
    logic [1:0] credits;
    logic       overflow;
    logic       LED_Green;
    logic       LED_Yellow;

    modport master (
        output dispense, cup_present,
        input  cup_drop, heater_on, valve_open, served, busy, credits,
               overflow, LED_Green, LED_Yellow
    );

    modport slave (
        input  dispense, cup_present,
        output cup_drop, heater_on, valve_open, served, busy, credits,
               overflow, LED_Green, LED_Yellow
    );
endinterface

// File: rtl/coffee_dispense_ctrl.sv
// rtl/coffee_dispense_ctrl.sv - timed coffee serve sequencer with buffered request credits
//
// Purpose: consumes dispense pulses and runs CUP -> BREW -> POUR -> DONE with
// fixed-length phases; requests arriving mid-serve are stored as credits and
// served back-to-back.
// Ports:
//   i_clk  clock, all logic on posedge
//   i_rst  synchronous active-high reset
//   bus    coffee_dispense_ctrl_if.slave (see interface file for signals)
// Optional feature macro: COFFEE_CUP_SENSE_EN adds a WAIT_CUP state after CUP
// and aborts BREW/POUR into DONE when the cup is removed.

module coffee_dispense_ctrl #(
    parameter int CUP_CYCLES  = 4,
    parameter int BREW_CYCLES = 16,
    parameter int POUR_CYCLES = 8,
    parameter int DONE_CYCLES = 4,
    parameter int MAX_CREDITS = 3
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    coffee_dispense_ctrl_if.slave       bus
);

    localparam logic [7:0] L_CUP_LAST  = 8'(CUP_CYCLES - 1);
    localparam logic [7:0] L_BREW_LAST = 8'(BREW_CYCLES - 1);
    localparam logic [7:0] L_POUR_LAST = 8'(POUR_CYCLES - 1);
    localparam logic [7:0] L_DONE_LAST = 8'(DONE_CYCLES - 1);
    localparam logic [1:0] L_MAX_CRED  = 2'(MAX_CREDITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CUP,
`ifdef COFFEE_CUP_SENSE_EN
        S_WAIT_CUP,
`endif
        S_BREW,
        S_POUR,
        S_DONE
    } state_t;

    state_t     r_state;
    logic [7:0] r_cnt;
    logic [1:0] r_credits;
    logic       r_cup_drop;
    logic       r_heater_on;
    logic       r_valve_open;
    logic       r_served;
    logic       r_busy;
    logic       r_overflow;
    logic       r_led_green;

    state_t     w_state_nxt;
    logic [7:0] w_cnt_nxt;
    logic [1:0] w_credits_nxt;
    logic       w_phase_last;
    logic       w_req_busy;
    logic       w_take;
    logic       w_overflow;

`ifndef COFFEE_CUP_SENSE_EN
    logic w_unused_cup_present;
    assign w_unused_cup_present = bus.cup_present;
`endif

    // A dispense seen while a serve is running is a credit request; one seen
    // in IDLE starts the serve directly.
    assign w_req_busy = bus.dispense && (r_state != S_IDLE);

    always_comb begin
        w_state_nxt  = r_state;
        w_phase_last = 1'b0;
        w_take       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (bus.dispense || (r_credits != 2'd0)) begin
                    w_state_nxt = S_CUP;
                end
                w_take = !bus.dispense && (r_credits != 2'd0);
            end
            S_CUP: begin
                w_phase_last = (r_cnt == L_CUP_LAST);
                if (w_phase_last) begin
`ifdef COFFEE_CUP_SENSE_EN
                    w_state_nxt = S_WAIT_CUP;
`else
                    w_state_nxt = S_BREW;
`endif
                end
            end
`ifdef COFFEE_CUP_SENSE_EN
            S_WAIT_CUP: begin
                if (bus.cup_present) begin
                    w_state_nxt = S_BREW;
                end
            end
`endif
            S_BREW: begin
                w_phase_last = (r_cnt == L_BREW_LAST);
`ifdef COFFEE_CUP_SENSE_EN
                if (!bus.cup_present) begin
                    w_state_nxt = S_DONE;
                end else
`endif
                if (w_phase_last) begin
                    w_state_nxt = S_POUR;
                end
            end
            S_POUR: begin
                w_phase_last = (r_cnt == L_POUR_LAST);
`ifdef COFFEE_CUP_SENSE_EN
                if (!bus.cup_present) begin
                    w_state_nxt = S_DONE;
                end else
`endif
                if (w_phase_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_phase_last = (r_cnt == L_DONE_LAST);
                if (w_phase_last) begin
                    // A request arriving on this very cycle counts as a
                    // pending credit, so the next serve chains directly.
                    w_take      = (r_credits != 2'd0) || w_req_busy;
                    w_state_nxt = w_take ? S_CUP : S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Credit bookkeeping: a simultaneous add and take cancel out, which is
    // also why a full buffer never overflows on a chaining cycle.
    always_comb begin
        w_credits_nxt = r_credits;
        w_overflow    = 1'b0;
        if (w_take && !w_req_busy) begin
            w_credits_nxt = r_credits - 2'd1;
        end else if (w_req_busy && !w_take) begin
            if (r_credits != L_MAX_CRED) begin
                w_credits_nxt = r_credits + 2'd1;
            end else begin
                w_overflow = 1'b1;
            end
        end
    end

    // Counter restarts whenever the state changes; no state re-enters itself.
    assign w_cnt_nxt = (w_state_nxt != r_state) ? 8'd0 : r_cnt + 8'd1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= 8'd0;
            r_credits    <= 2'd0;
            r_cup_drop   <= 1'b0;
            r_heater_on  <= 1'b0;
            r_valve_open <= 1'b0;
            r_served     <= 1'b0;
            r_busy       <= 1'b0;
            r_overflow   <= 1'b0;
            r_led_green  <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_credits    <= w_credits_nxt;
            // Outputs are decoded from the next state so they line up with
            // the state they describe while staying registered.
            r_cup_drop   <= (w_state_nxt == S_CUP);
            r_heater_on  <= (w_state_nxt == S_BREW);
            r_valve_open <= (w_state_nxt == S_POUR);
            r_served     <= (w_state_nxt == S_DONE) && (w_cnt_nxt == L_DONE_LAST);
            r_busy       <= (w_state_nxt != S_IDLE);
            r_overflow   <= w_overflow;
            r_led_green  <= (w_state_nxt == S_IDLE) && (w_credits_nxt == 2'd0);
        end
    end

    assign bus.cup_drop   = r_cup_drop;
    assign bus.heater_on  = r_heater_on;
    assign bus.valve_open = r_valve_open;
    assign bus.served     = r_served;
    assign bus.busy       = r_busy;
    assign bus.credits    = r_credits;
    assign bus.overflow   = r_overflow;
    assign bus.LED_Green  = r_led_green;
    assign bus.LED_Yellow = r_busy;

endmodule

// File: tb/tb_coffee_dispense_ctrl.sv
// tb/tb_coffee_dispense_ctrl.sv - directed self-checking bench for coffee_dispense_ctrl

module tb_coffee_dispense_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    coffee_dispense_ctrl_if bus ();

    coffee_dispense_ctrl dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // per-sample capture, index k = k-th cycle after the first stimulus edge
    logic       s_busy  [0:200];
    logic       s_cup   [0:200];
    logic       s_heat  [0:200];
    logic       s_valve [0:200];
    logic       s_served[0:200];
    logic       s_ovf   [0:200];
    logic       s_green [0:200];
    logic [1:0] s_cred  [0:200];
    int c_cup, c_heat, c_valve, c_busy, c_served, c_ovf, c_multi, first_served;

    int disp_at[$];
    int rst_at;
    int cp_hi_at;
    int cp_lo_at;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.dispense = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Iteration i drives inputs at a negedge; the next negedge gives sample i+1.
    task automatic run(input int n);
        c_cup = 0; c_heat = 0; c_valve = 0; c_busy = 0;
        c_served = 0; c_ovf = 0; c_multi = 0; first_served = 0;
        for (int i = 0; i < n; i++) begin
            bus.dispense = 1'b0;
            foreach (disp_at[k]) if (disp_at[k] == i) bus.dispense = 1'b1;
            rst = (i == rst_at);
            if (i == cp_hi_at) bus.cup_present = 1'b1;
            if (i == cp_lo_at) bus.cup_present = 1'b0;
            @(negedge clk);
            s_busy[i+1]   = bus.busy;
            s_cup[i+1]    = bus.cup_drop;
            s_heat[i+1]   = bus.heater_on;
            s_valve[i+1]  = bus.valve_open;
            s_served[i+1] = bus.served;
            s_ovf[i+1]    = bus.overflow;
            s_green[i+1]  = bus.LED_Green;
            s_cred[i+1]   = bus.credits;
            c_cup    += int'(bus.cup_drop);
            c_heat   += int'(bus.heater_on);
            c_valve  += int'(bus.valve_open);
            c_busy   += int'(bus.busy);
            c_served += int'(bus.served);
            c_ovf    += int'(bus.overflow);
            if ((int'(bus.cup_drop) + int'(bus.heater_on) + int'(bus.valve_open)) > 1) c_multi++;
            if (bus.served && first_served == 0) first_served = i + 1;
        end
        bus.dispense = 1'b0;
        rst = 1'b0;
    endtask

    initial begin
        bus.dispense    = 1'b0;
        bus.cup_present = 1'b1;
        rst_at   = -1;
        cp_hi_at = -1;
        cp_lo_at = -1;

        // reset state
        do_reset();
        @(negedge clk);
        chk("rst_green",   int'(bus.LED_Green),  1);
        chk("rst_yellow",  int'(bus.LED_Yellow), 0);
        chk("rst_busy",    int'(bus.busy),       0);
        chk("rst_credits", int'(bus.credits),    0);
        chk("rst_act",     int'(bus.cup_drop) + int'(bus.heater_on) + int'(bus.valve_open), 0);
        chk("rst_served",  int'(bus.served),     0);

`ifndef COFFEE_CUP_SENSE_EN
        // single serve
        disp_at = '{0};
        run(40);
        chk("s1_busy_first", int'(s_busy[1]), 1);
        chk("s1_cup_first",  int'(s_cup[1]),  1);
        chk("s1_heat_at5",   int'(s_heat[5]), 1);
        chk("s1_cup_cnt",    c_cup,   4);
        chk("s1_heat_cnt",   c_heat,  16);
        chk("s1_valve_cnt",  c_valve, 8);
        chk("s1_busy_cnt",   c_busy,  32);
        chk("s1_served_idx", first_served, 32);
        chk("s1_served_cnt", c_served, 1);
        chk("s1_onehot",     c_multi, 0);
        chk("s1_green_end",  int'(s_green[40]), 1);

        // three credits during BREW, four back-to-back serves
        disp_at = '{0, 6, 8, 10};
        run(140);
        chk("bb_credits_3",   int'(s_cred[11]), 3);
        chk("bb_credits_33",  int'(s_cred[33]), 2);
        chk("bb_busy_cnt",    c_busy, 128);
        chk("bb_busy_128",    int'(s_busy[128]), 1);
        chk("bb_busy_129",    int'(s_busy[129]), 0);
        chk("bb_cup_33",      int'(s_cup[33]), 1);
        chk("bb_served_cnt",  c_served, 4);
        chk("bb_served_128",  int'(s_served[128]), 1);
        chk("bb_credits_end", int'(s_cred[129]), 0);
        chk("bb_green_end",   int'(s_green[129]), 1);
        chk("bb_onehot",      c_multi, 0);

        // overflow on the fourth buffered request
        disp_at = '{0, 6, 8, 10, 12};
        run(20);
        chk("of_credits", int'(s_cred[13]), 3);
        chk("of_pulse",   int'(s_ovf[13]), 1);
        chk("of_cnt",     c_ovf, 1);
        do_reset();

        // dispense on the final DONE cycle with one credit pending
        disp_at = '{0, 6, 32};
        run(66);
        chk("dc_served_32", int'(s_served[32]), 1);
        chk("dc_cup_33",    int'(s_cup[33]),  1);
        chk("dc_busy_33",   int'(s_busy[33]), 1);
        chk("dc_credits",   int'(s_cred[33]), 1);
        chk("dc_ovf",       c_ovf, 0);
        chk("dc_cup_65",    int'(s_cup[65]), 1);
        chk("dc_cred_65",   int'(s_cred[65]), 0);
        do_reset();

        // reset during POUR
        disp_at = '{0, 6};
        rst_at  = 24;
        run(26);
        rst_at  = -1;
        chk("rp_valve_24", int'(s_valve[24]), 1);
        chk("rp_act_25",   int'(s_cup[25]) + int'(s_heat[25]) + int'(s_valve[25]), 0);
        chk("rp_cred_25",  int'(s_cred[25]), 0);
        chk("rp_green_25", int'(s_green[25]), 1);
        chk("rp_busy_25",  int'(s_busy[25]), 0);
`else
        // cup sensing: hold in WAIT_CUP, start BREW on cup, abort POUR on removal
        bus.cup_present = 1'b0;
        disp_at  = '{0};
        cp_hi_at = 10;
        cp_lo_at = 29;
        run(40);
        chk("cs_cup_4",      int'(s_cup[4]),  1);
        chk("cs_wait_act",   int'(s_cup[10]) + int'(s_heat[10]) + int'(s_valve[10]), 0);
        chk("cs_wait_busy",  int'(s_busy[10]), 1);
        chk("cs_heat_11",    int'(s_heat[11]), 1);
        chk("cs_valve_29",   int'(s_valve[29]), 1);
        chk("cs_valve_30",   int'(s_valve[30]), 0);
        chk("cs_served_32",  int'(s_served[32]), 0);
        chk("cs_served_33",  int'(s_served[33]), 1);
        chk("cs_busy_cnt",   c_busy, 33);
        chk("cs_green_end",  int'(s_green[40]), 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/coffee_dispense_ctrl.md
# coffee_dispense_ctrl

Downstream stage of the coin-summing FSM: consumes its one-cycle `dispense` pulse and sequences the physical serve (cup drop, brew, pour, done) with fixed-length timed phases. Paid requests arriving while a serve is in progress are buffered as credits and served back-to-back. This block drives the actuator enables and the machine status LEDs.

## Interface
- `CUP_CYCLES`, default 4: cycles `cup_drop` is held high (1–255).
- `BREW_CYCLES`, default 16: cycles `heater_on` is held high (1–255).
- `POUR_CYCLES`, default 8: cycles `valve_open` is held high (1–255).
- `DONE_CYCLES`, default 4: cycles of the done/settle phase (1–255).
- `MAX_CREDITS`, default 3: credit buffer depth (1–3; counter is 2 bits).

Ports:
- `clk` in 1: single clock, all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `dispense` in 1: one-cycle pulse per paid request from the sum FSM.
- `cup_present` in 1: cup sensor, 1 = cup in place.
- `cup_drop` out 1: cup release actuator.
- `heater_on` out 1: brew heater enable.
- `valve_open` out 1: pour valve enable.
- `served` out 1: one-cycle pulse on the final DONE cycle.
- `busy` out 1: high in every state except IDLE.
- `credits` out 2: buffered requests not yet started.
- `overflow` out 1: one-cycle pulse when a request is dropped because the buffer is full.
- `LED_Green` out 1: ready; high only in IDLE with `credits == 0`.
- `LED_Yellow` out 1: equal to `busy`.

## Operation
- States: IDLE, CUP, BREW, POUR, DONE, plus WAIT_CUP when `CUP_SENSE_EN` is defined.
- One 8-bit phase counter. It loads 0 on phase entry and increments each cycle. A phase ends on the cycle where counter == N-1.
- IDLE: if `dispense` or `credits > 0`, go to CUP. When starting from credits, decrement `credits`. A `dispense` pulse starts the serve directly and does not touch `credits`.
- CUP: `cup_drop` = 1 for `CUP_CYCLES`. Then go to BREW, or to WAIT_CUP if the macro is defined.
- BREW: `heater_on` = 1 for `BREW_CYCLES`, then POUR.
- POUR: `valve_open` = 1 for `POUR_CYCLES`, then DONE.
- DONE: all actuators 0 for `DONE_CYCLES`. `served` = 1 on the last DONE cycle.
- After DONE: if `credits > 0` (after this cycle's update), go directly to CUP and decrement `credits`. Otherwise go to IDLE.
- `dispense` while `busy`: increment `credits` if below `MAX_CREDITS`. Otherwise pulse `overflow` and drop the request.
- Simultaneous `dispense` and credit consumption on the same cycle: `credits` is unchanged, and `overflow` is never raised for that request.
- Actuator outputs are one-hot-or-zero. `cup_drop`, `heater_on` and `valve_open` are never high together.
- Reset mid-serve: abort immediately. Actuators go low the next cycle and credits are lost.

## Timing
- Reset values: state IDLE, `credits` 0, `cup_drop`/`heater_on`/`valve_open`/`served`/`overflow`/`busy`/`LED_Yellow` 0, `LED_Green` 1.
- All outputs are registered.
- `dispense` sampled high at edge T gives `busy` and `cup_drop` = 1 from T+1.
- Serve length with defaults: 32 cycles of `busy` (T+1..T+32). `served` is high at T+32.
- With a credit pending, CUP restarts at T+33 and `busy` stays high continuously.

## Configuration
- `COFFEE_CUP_SENSE_EN` defined:
  - WAIT_CUP is inserted after CUP. It holds with all actuators 0 until `cup_present` = 1, then goes to BREW the next cycle.
  - If `cup_present` falls during BREW or POUR, go to DONE immediately with actuators off. `served` still pulses at the end of DONE.
  - `busy` stays high throughout.
- Not defined: WAIT_CUP does not exist, `cup_present` is ignored, and CUP goes straight to BREW.

## Test plan
- Reset, then a single `dispense` pulse → `cup_drop` high 4 cycles, `heater_on` 16, `valve_open` 8. `served` high exactly at the 32nd busy cycle. `LED_Green` returns to 1 afterwards.
- Three `dispense` pulses during the BREW phase → `credits` reaches 3. Three further serves run back-to-back with no IDLE gap (`busy` continuous for 128 cycles). `credits` ends at 0.
- Four pulses while busy with `MAX_CREDITS` = 3 → `credits` = 3 and exactly one `overflow` pulse, on the fourth.
- `dispense` on the same cycle as the final DONE cycle with `credits` = 1 → next serve starts at once and `credits` stays 1.
- Assert `rst` during POUR → all actuators 0 the next cycle, `credits` 0, `LED_Green` 1.
- With `COFFEE_CUP_SENSE_EN` defined and `cup_present` = 0 → the FSM holds in WAIT_CUP. Raise `cup_present` → BREW starts the next cycle. Drop `cup_present` during POUR → `valve_open` falls the next cycle and `served` follows after 4 cycles of DONE.
